// File: rtl/sequence_encoder.sv
// -----------------------------------------------------------------------------
// sequence_encoder
//
// Packs per-step DAC/PDM set-points and control flags into 64-bit sequence
// words and writes them into sequence memory through a BRAM write port.
// A start pulse latches base address and word count. Accepted step beats are
// then written to consecutive addresses, wrapping at 2^ADDR_W, until the count
// is reached or abort is pulsed.
//
// Build option:
//   SEQ_ENC_SATURATE_EN  defined   -> DAC values clamped to [-8192, 8191] and
//                                     sat_flag reports clipping.
//                        undefined -> DAC values truncated to bits [13:0] and
//                                     sat_flag stays 0.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start, abort      run control pulses (abort wins when both are high)
//   base_addr, length first word address and word count, latched on start
//   s_valid, s_ready  step-beat handshake
//   s_mode            0 = DAC word, 1 = PDM word
//   s_dac0, s_dac1    signed 16-bit DAC set-points
//   s_pdm0..s_pdm3    unsigned 11-bit PDM values
//   s_enable          channel enable flags
//   s_ramp_down       DAC ramp-down enables
//   s_dac_reset       DAC reset flag
//   bram_addr, bram_din, bram_we  registered BRAM write port
//   busy              high while accepting beats
//   done              one-cycle pulse when the run completes (not on abort)
//   sat_flag          sticky: a DAC value was clipped during this run
// -----------------------------------------------------------------------------
module sequence_encoder #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_mode,
  input  logic [15:0]       s_dac0,
  input  logic [15:0]       s_dac1,
  input  logic [10:0]       s_pdm0,
  input  logic [10:0]       s_pdm1,
  input  logic [10:0]       s_pdm2,
  input  logic [10:0]       s_pdm3,
  input  logic [3:0]        s_enable,
  input  logic [1:0]        s_ramp_down,
  input  logic              s_dac_reset,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [63:0]       bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic              accept;
  logic              start_ok;
  logic              last_beat;
  logic [13:0]       dac0_14, dac1_14;
  logic              clip0, clip1;
  logic              clip_any;
  logic [63:0]       packed_word;

  assign accept    = s_valid && s_ready;
  assign start_ok  = (state == ST_IDLE) && start && !abort;
  // count is always below len_q in RUN, so len_q - 1 cannot underflow there.
  assign last_beat = (count == len_q - LEN_W'(1));

  // ---------------------------------------------------------------------------
  // DAC 16 -> 14 bit conversion
  // ---------------------------------------------------------------------------
`ifdef SEQ_ENC_SATURATE_EN
  // Out of range exactly when bits [15:13] are not all equal.
  assign clip0   = (s_dac0[15:13] != 3'b000) && (s_dac0[15:13] != 3'b111);
  assign clip1   = (s_dac1[15:13] != 3'b000) && (s_dac1[15:13] != 3'b111);
  assign dac0_14 = !clip0 ? s_dac0[13:0] : (s_dac0[15] ? 14'h2000 : 14'h1FFF);
  assign dac1_14 = !clip1 ? s_dac1[13:0] : (s_dac1[15] ? 14'h2000 : 14'h1FFF);
`else
  logic unused_dac_msbs;
  assign unused_dac_msbs = ^{s_dac0[15:14], s_dac1[15:14]};
  assign clip0   = 1'b0;
  assign clip1   = 1'b0;
  assign dac0_14 = s_dac0[13:0];
  assign dac1_14 = s_dac1[13:0];
`endif

  // Only DAC words carry DAC values, so only they can clip.
  assign clip_any = !s_mode && (clip0 || clip1);

  // ---------------------------------------------------------------------------
  // Word packing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    packed_word          = '0;
    packed_word[14]      = s_dac_reset;
    packed_word[47:46]   = s_ramp_down;
    packed_word[63:60]   = s_enable;
    if (!s_mode) begin
      packed_word[13:0]  = dac0_14;
      packed_word[29:16] = dac1_14;
      packed_word[31:30] = {2{dac1_14[13]}};
    end else begin
      packed_word[10:0]  = s_pdm0;
      packed_word[26:16] = s_pdm1;
      packed_word[42:32] = s_pdm2;
      packed_word[58:48] = s_pdm3;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start_ok) state_next = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)                       state_next = ST_IDLE;
        else if (accept && last_beat)    state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_ready = (state == ST_RUN);
    busy    = (state == ST_RUN);
    done    = (state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Run bookkeeping and registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      len_q     <= '0;
      count     <= '0;
      sat_flag  <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      // A beat accepted on the same edge as abort still gets written.
      bram_we <= accept;
      if (start_ok) begin
        wr_addr  <= base_addr;
        len_q    <= length;
        count    <= '0;
        sat_flag <= 1'b0;
      end
      if (accept) begin
        bram_addr <= wr_addr;
        bram_din  <= packed_word;
        wr_addr   <= wr_addr + ADDR_W'(1);  // wraps silently at 2^ADDR_W
        count     <= count + LEN_W'(1);
        if (clip_any) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sequence_encoder.sv
// -----------------------------------------------------------------------------
// tb_sequence_encoder
//
// Directed and randomized runs of sequence_encoder. Expected BRAM writes are
// built from the word-format rules with plain integer arithmetic and compared
// with the writes captured at the BRAM port.
// -----------------------------------------------------------------------------
module tb_sequence_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] length = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_mode = 1'b0;
  logic [15:0] s_dac0 = '0, s_dac1 = '0;
  logic [10:0] s_pdm0 = '0, s_pdm1 = '0, s_pdm2 = '0, s_pdm3 = '0;
  logic [3:0]  s_enable = '0;
  logic [1:0]  s_ramp_down = '0;
  logic        s_dac_reset = 1'b0;
  logic [13:0] bram_addr;
  logic [63:0] bram_din;
  logic        bram_we;
  logic        busy;
  logic        done;
  logic        sat_flag;

  sequence_encoder #(.ADDR_W(14), .LEN_W(15)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
    .s_dac0(s_dac0), .s_dac1(s_dac1),
    .s_pdm0(s_pdm0), .s_pdm1(s_pdm1), .s_pdm2(s_pdm2), .s_pdm3(s_pdm3),
    .s_enable(s_enable), .s_ramp_down(s_ramp_down), .s_dac_reset(s_dac_reset),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] dac0, dac1;
    logic [10:0] pdm0, pdm1, pdm2, pdm3;
    logic [3:0]  enable;
    logic [1:0]  ramp;
    logic        dac_reset;
  } beat_t;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] din;
    int          cyc;
  } wr_t;

  wr_t   wr_q[$];
  wr_t   exp_q[$];
  beat_t plan[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  bit    exp_sat = 1'b0;
  int    checks = 0;
  int    failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_we) wr_q.push_back('{bram_addr, bram_din, cyc});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit clips(input logic [15:0] raw);
`ifdef SEQ_ENC_SATURATE_EN
    int v = int'($signed(raw));
    return (v > 8191) || (v < -8192);
`else
    return (raw === 16'hxxxx);
`endif
  endfunction

  function automatic longint unsigned field14(input logic [15:0] raw);
    int v = int'($signed(raw));
`ifdef SEQ_ENC_SATURATE_EN
    if (v > 8191)       v = 8191;
    else if (v < -8192) v = -8192;
`endif
    return longint'((v + 65536) % 16384);
  endfunction

  function automatic logic [63:0] pack_model(input beat_t b);
    longint unsigned w, f0, f1;
    w = (64'(b.enable) << 60) + (64'(b.ramp) << 46) + (64'(b.dac_reset) << 14);
    if (b.mode == 1'b0) begin
      f0 = field14(b.dac0);
      f1 = field14(b.dac1);
      w += f0 + (f1 << 16);
      if (f1 >= 8192) w += 64'd3 << 30;  // sign copies above the dac1 field
    end else begin
      w += 64'(b.pdm0) + (64'(b.pdm1) << 16) + (64'(b.pdm2) << 32) + (64'(b.pdm3) << 48);
    end
    return w;
  endfunction

  function automatic logic [15:0] pick_dac();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'(8190 + int'($urandom_range(0, 3)));
      2:       return 16'(-8194 + int'($urandom_range(0, 3)));
      default: return 16'($urandom_range(0, 2000));
    endcase
  endfunction

  function automatic beat_t next_beat();
    beat_t b;
    if (plan.size() > 0) return plan.pop_front();
    b.mode      = 1'($urandom_range(0, 1));
    b.dac0      = pick_dac();
    b.dac1      = pick_dac();
    b.pdm0      = 11'($urandom);
    b.pdm1      = 11'($urandom);
    b.pdm2      = 11'($urandom);
    b.pdm3      = 11'($urandom);
    b.enable    = 4'($urandom);
    b.ramp      = 2'($urandom);
    b.dac_reset = 1'($urandom);
    return b;
  endfunction

  task automatic drive(input beat_t b);
    s_mode = b.mode;   s_dac0 = b.dac0;  s_dac1 = b.dac1;
    s_pdm0 = b.pdm0;   s_pdm1 = b.pdm1;  s_pdm2 = b.pdm2;  s_pdm3 = b.pdm3;
    s_enable = b.enable; s_ramp_down = b.ramp; s_dac_reset = b.dac_reset;
  endtask

  // ---------------------------------------------------------------------------
  // Run helpers
  // ---------------------------------------------------------------------------
  task automatic begin_run(input logic [13:0] base, input logic [14:0] len);
    wr_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    exp_sat   = 1'b0;
    base_addr = base;
    length    = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_beats(input logic [13:0] base, input int nbeats,
                           input int max_gap, input bit poke_start);
    beat_t b;
    bit    accepted;
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        s_valid = 1'b0;
        tick();
      end
      b = next_beat();
      drive(b);
      s_valid = 1'b1;
      if (poke_start && k == 1) begin
        start     = 1'b1;
        base_addr = 14'h0AAA;
        length    = 15'd7;
      end
      accepted = 1'b0;
      for (int t = 0; t < 50 && !accepted; t++) begin
        @(negedge clk);
        if (s_ready) accepted = 1'b1;
        tick();
        start = 1'b0;
      end
      check("beat_accepted", 64'(accepted), 64'd1);
      exp_q.push_back('{14'(int'(base) + k), pack_model(b), 0});
      if (b.mode == 1'b0 && (clips(b.dac0) || clips(b.dac1))) exp_sat = 1'b1;
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int exp_done);
    s_valid = 1'b0;
    repeat (3) tick();
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wr_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_din%0d", tag, i), wr_q[i].din, exp_q[i].din);
    end
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    if (exp_done != 0 && wr_q.size() > 0)
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'(wr_q[wr_q.size()-1].cyc));
    check({tag, "_sat_flag"}, 64'(sat_flag), 64'(exp_sat));
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    beat_t       b;
    logic [63:0] din0;
    logic [13:0] rnd_base;
    logic [14:0] rnd_len;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_bram_we", 64'(bram_we), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_bram_din", bram_din, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    rst = 1'b0;
    tick();

    // Single DAC word
    b = '{mode: 1'b0, dac0: 16'h0123, dac1: 16'hFFFB, pdm0: '0, pdm1: '0, pdm2: '0,
          pdm3: '0, enable: 4'h3, ramp: 2'b00, dac_reset: 1'b1};
    plan.push_back(b);
    begin_run(14'h0100, 15'd1);
    run_beats(14'h0100, 1, 0, 1'b0);
    finish_check("dac_word", 1);
    din0 = (wr_q.size() > 0) ? wr_q[0].din : 64'd0;
    check("dac_word_literal", din0, 64'h3000_0000_FFFB_4123);

    // Single PDM word
    b = '{mode: 1'b1, dac0: 16'h1234, dac1: 16'h5678, pdm0: 11'h7FF, pdm1: 11'h001,
          pdm2: 11'h400, pdm3: 11'h2AA, enable: 4'hF, ramp: 2'b10, dac_reset: 1'b0};
    plan.push_back(b);
    begin_run(14'h0200, 15'd1);
    run_beats(14'h0200, 1, 0, 1'b0);
    finish_check("pdm_word", 1);
    din0 = (wr_q.size() > 0) ? wr_q[0].din : 64'd0;
    check("pdm_word_literal", din0, 64'hF2AA_8400_0001_07FF);

    // Out-of-range DAC values
    b = '{mode: 1'b0, dac0: 16'd20000, dac1: 16'(-20000), pdm0: '0, pdm1: '0, pdm2: '0,
          pdm3: '0, enable: 4'h0, ramp: 2'b00, dac_reset: 1'b0};
    plan.push_back(b);
    begin_run(14'h0300, 15'd1);
    run_beats(14'h0300, 1, 0, 1'b0);
    finish_check("sat_word", 1);
    din0 = (wr_q.size() > 0) ? wr_q[0].din : 64'd0;
`ifdef SEQ_ENC_SATURATE_EN
    check("sat_dac0_field", 64'(din0[13:0]), 64'h1FFF);
    check("sat_dac1_field", 64'(din0[31:16]), 64'hE000);
    check("sat_flag_set", 64'(sat_flag), 64'd1);
`else
    check("sat_dac0_field", 64'(din0[13:0]), 64'h0E20);
    check("sat_flag_off", 64'(sat_flag), 64'd0);
`endif

    // Streaming across the address wrap with s_valid held high
    begin_run(14'h3FFE, 15'd4);
    run_beats(14'h3FFE, 4, 0, 1'b0);
    finish_check("stream_wrap", 1);
    for (int i = 1; i < wr_q.size(); i++)
      check($sformatf("stream_consecutive%0d", i), 64'(wr_q[i].cyc), 64'(wr_q[i-1].cyc + 1));

    // Abort after 2 of 5 beats
    begin_run(14'h0010, 15'd5);
    run_beats(14'h0010, 2, 1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_s_ready", 64'(s_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    finish_check("abort", 0);

    // length = 0: done pulse, no writes
    begin_run(14'h0400, 15'd0);
    finish_check("len_zero", 1);

    // start pulsed during RUN is ignored
    begin_run(14'h0500, 15'd3);
    run_beats(14'h0500, 3, 2, 1'b1);
    finish_check("start_in_run", 1);

    // start and abort together in IDLE: stay IDLE
    done_cnt  = 0;
    length    = 15'd3;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_ready", 64'(s_ready), 64'd0);
    tick();
    check("start_abort_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset with a write in flight
    begin_run(14'h0600, 15'd4);
    drive(next_beat());
    s_valid = 1'b1;
    tick();
    check("rst_mid_we_before", 64'(bram_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", 64'(bram_we), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(s_ready), 64'd0);
    check("rst_mid_addr", 64'(bram_addr), 64'd0);
    check("rst_mid_din", bram_din, 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      rnd_base = 14'($urandom);
      rnd_len  = 15'($urandom_range(1, 12));
      begin_run(rnd_base, rnd_len);
      run_beats(rnd_base, int'(rnd_len), 3, 1'b0);
      finish_check($sformatf("rand%0d", r), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
